stage3: RTL
===========

Name: stage3

Overview:
- Execute stage of the 5-stage CPU pipeline.
- Consumes the ID/EX register outputs (r1, r2, rd, imm, PC, op_data). Computes the ALU result, branch/jump decision and target, then registers them into the EX/MEM boundary.
- Single-cycle ALU ops complete in one cycle. MUL/DIVU/REMU run on an iterative 32-step unit and hold the upstream stage via stall.

Parameters:
- XLEN, 32, datapath width
- MD_STEPS, 32, iterations per multiply/divide (equals XLEN)

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-low reset, sampled on posedge clk
- en  in  1  pipeline enable; 0 freezes all state including the FSM
- r1  in  32  rs1 value
- r2  in  32  rs2 value
- rd  in  5  destination register
- imm  in  32  sign-extended immediate
- PC  in  32  instruction PC
- op_data  in  11  control word: [3:0] alu_op, [4] use_imm, [5] use_pc, [6] reg_write, [7] mem_read, [8] mem_write, [9] branch, [10] jump
- stall  out  1  combinational; 1 = upstream must hold its register
- alu_result_out  out  32  registered result / memory address
- r2_out  out  32  registered store data
- rd_out  out  5  registered destination
- op_data_out  out  11  registered control word
- branch_taken_out  out  1  registered redirect request
- branch_target_out  out  32  registered redirect target

Behaviour:
- Reset (rst=0 at posedge): all outputs 0, FSM=IDLE, count=0. Applies mid-operation; any in-flight MUL/DIV is discarded.
- Reset output: stall is 0 while rst=0.
- Operand selection: A = use_pc ? PC : r1; B = use_imm ? imm : r2.
- alu_op 0–12 (single-cycle): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB, SEQ, SNE.
  - Shifts use B[4:0].
  - SLT/SLTU/SEQ/SNE yield 0 or 1.
  - Wrap-around arithmetic is mod 2^32, with no flags.
- alu_op 13–15 (multi-cycle): MUL (low 32 bits), DIVU, REMU (unsigned).
- Jump: when op_data[10]=1, alu_result = PC+4 regardless of alu_op.
  - Target = use_pc ? PC+imm : (r1+imm) & ~1.
  - taken = 1.
- Branch: when op_data[9]=1, taken = alu_result[0] and target = PC+imm. Otherwise taken = 0.
- Single-cycle path (FSM=IDLE, en=1, non-multi op): at posedge, all output registers load. Latency is 1 cycle.
- FSM states:
  - IDLE:
    - en=1 and multi op: latch operands, rd, op_data and alu_op; go to BUSY with count=0.
    - Output registers load a bubble: op_data_out=0, rd_out=0, taken=0, others 0.
  - BUSY:
    - Each enabled edge performs one shift-add or restoring-divide step and count++.
    - On the edge with count==MD_STEPS-1: final step, outputs load the result with the latched rd/op_data/r2, and FSM returns to IDLE.
- stall = (IDLE & en & multi op) | (BUSY & count != MD_STEPS-1).
  - It is high for exactly 32 cycles per multi op.
  - It drops in the last BUSY cycle so upstream advances on the same edge the result is written.
- Divide by zero falls out of the restoring algorithm: DIVU = 0xFFFFFFFF, REMU = dividend. There is no special case.
- en=0: no register, FSM or count changes. stall still reflects the current state.

Decomposition:
- Shared package ex_pkg holds:
  - alu_op encodings
  - op_data bit indices
  - FSM state encoding
  - XLEN
- One natural sub-module: mul_div_iter.
  - Inputs: start, op, a, b.
  - Outputs: result, last_step.
  - Contains the 32-step shift-add/restoring-divide datapath and counter.
- stage3 keeps the ALU, branch logic, FSM glue and output registers.

Test Plan:
- ADD r1=0xFFFFFFFF, r2=1, use_imm=0 -> alu_result_out=0 one cycle later; stall stays 0.
- Branch with SLT r1=-5, r2=3, PC=0x100, imm=0x20 -> branch_taken_out=1, branch_target_out=0x120.
- JALR (jump, use_pc=0) r1=0x1001, imm=4, PC=0x40 -> alu_result_out=0x44, target=0x1004, taken=1.
- MUL r1=0x10000, r2=0x10001 -> stall high 32 cycles, bubble outputs meanwhile; then alu_result_out=0x00010000 with the latched rd.
- DIVU r1=100, r2=0 -> 0xFFFFFFFF; REMU r1=100, r2=7 -> 2.
- DIVU started, rst=0 at BUSY cycle 10 -> next cycle: all outputs 0, stall=0, FSM IDLE. A following ADD completes in 1 cycle.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: widths, control-word bit
// positions, ALU opcodes and the multiply/divide sequencing states.
package ex_pkg;

    localparam int XLEN     = 32;
    localparam int MD_STEPS = 32;
    localparam int CNT_W    = $clog2(MD_STEPS);
    localparam int OPW      = 11;

    // op_data bit positions ([3:0] holds alu_op)
    localparam int OP_USE_IMM   = 4;
    localparam int OP_USE_PC    = 5;
    localparam int OP_REG_WRITE = 6;
    localparam int OP_MEM_READ  = 7;
    localparam int OP_MEM_WRITE = 8;
    localparam int OP_BRANCH    = 9;
    localparam int OP_JUMP      = 10;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10,
        ALU_SEQ   = 4'd11,
        ALU_SNE   = 4'd12,
        ALU_MUL   = 4'd13,
        ALU_DIVU  = 4'd14,
        ALU_REMU  = 4'd15
    } alu_op_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } ex_state_t;

    function automatic logic is_md_op(input alu_op_t op);
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/mul_div_iter.sv
// Iterative 32-step multiplier (shift-add) / unsigned restoring divider.
// Ports: start loads operands, step advances one iteration, result is the
// value produced by the current step, last_step flags the final iteration.
module mul_div_iter
    import ex_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            step,
    input  alu_op_t         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            last_step
);

    // acc: product (MUL) or partial remainder (DIV)
    // x  : multiplicand (MUL) or dividend shifting into quotient (DIV)
    // y  : multiplier (MUL) or divisor (DIV)
    alu_op_t          op_q, op_d;
    logic [XLEN-1:0]  acc_q, acc_d;
    logic [XLEN-1:0]  x_q, x_d;
    logic [XLEN-1:0]  y_q, y_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [XLEN:0]    rem_sh;
    logic [XLEN-1:0]  rem_diff;
    logic             rem_ge;

    always_comb begin
        rem_sh   = {acc_q, x_q[XLEN-1]};
        rem_ge   = rem_sh >= {1'b0, y_q};
        // Only used when rem_sh >= y, where the true difference is < y
        rem_diff = rem_sh[XLEN-1:0] - y_q;
    end

    always_comb begin
        op_d    = op_q;
        acc_d   = acc_q;
        x_d     = x_q;
        y_d     = y_q;
        count_d = count_q;
        if (start) begin
            op_d    = op;
            acc_d   = '0;
            x_d     = a;
            y_d     = b;
            count_d = '0;
        end else if (step) begin
            count_d = count_q + 1'b1;
            if (op_q == ALU_MUL) begin
                acc_d = y_q[0] ? acc_q + x_q : acc_q;
                x_d   = x_q << 1;
                y_d   = y_q >> 1;
            end else if (rem_ge) begin
                acc_d = rem_diff;
                x_d   = {x_q[XLEN-2:0], 1'b1};
            end else begin
                acc_d = rem_sh[XLEN-1:0];
                x_d   = {x_q[XLEN-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q    <= ALU_ADD;
            acc_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            count_q <= '0;
        end else begin
            op_q    <= op_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            y_q     <= y_d;
            count_q <= count_d;
        end
    end

    // Next-state view so the final step's value is visible on the same edge
    assign result    = (op_q == ALU_DIVU) ? x_d : acc_d;
    assign last_step = count_q == CNT_W'(MD_STEPS - 1);

endmodule

// File: rtl/stage3.sv
// Execute stage: operand select, ALU, branch/jump resolution, iterative
// MUL/DIVU/REMU sequencing and the EX/MEM output registers.
// Inputs: ID/EX bundle (r1, r2, rd, imm, PC, op_data), en, rst (active low).
// Outputs: stall (comb) and the registered EX/MEM fields.
module stage3
    import ex_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [XLEN-1:0] r1,
    input  logic [XLEN-1:0] r2,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] PC,
    input  logic [OPW-1:0]  op_data,
    output logic            stall,
    output logic [XLEN-1:0] alu_result_out,
    output logic [XLEN-1:0] r2_out,
    output logic [4:0]      rd_out,
    output logic [OPW-1:0]  op_data_out,
    output logic            branch_taken_out,
    output logic [XLEN-1:0] branch_target_out
);

    alu_op_t         alu_op;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      shamt;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] ex_res;
    logic            ex_taken;
    logic [XLEN-1:0] ex_target;
    logic            md_op;
    logic            md_start;
    logic            md_step;
    logic [XLEN-1:0] md_result;
    logic            md_last;

    ex_state_t       state_q, state_d;
    logic [4:0]      rd_lat_q, rd_lat_d;
    logic [OPW-1:0]  op_lat_q, op_lat_d;
    logic [XLEN-1:0] r2_lat_q, r2_lat_d;

    logic [XLEN-1:0] res_q, res_d;
    logic [XLEN-1:0] r2o_q, r2o_d;
    logic [4:0]      rdo_q, rdo_d;
    logic [OPW-1:0]  opo_q, opo_d;
    logic            tk_q, tk_d;
    logic [XLEN-1:0] tgt_q, tgt_d;

    assign alu_op = alu_op_t'(op_data[3:0]);
    assign op_a   = op_data[OP_USE_PC]  ? PC  : r1;
    assign op_b   = op_data[OP_USE_IMM] ? imm : r2;
    assign shamt  = op_b[4:0];
    // A jump overrides alu_op, so it never enters the iterative unit
    assign md_op  = is_md_op(alu_op) && !op_data[OP_JUMP];

    always_comb begin
        alu_res = '0;
        unique case (alu_op)
            ALU_ADD:   alu_res = op_a + op_b;
            ALU_SUB:   alu_res = op_a - op_b;
            ALU_SLL:   alu_res = op_a << shamt;
            ALU_SLT:   alu_res = {{XLEN-1{1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:  alu_res = {{XLEN-1{1'b0}}, op_a < op_b};
            ALU_XOR:   alu_res = op_a ^ op_b;
            ALU_SRL:   alu_res = op_a >> shamt;
            ALU_SRA:   alu_res = $signed(op_a) >>> shamt;
            ALU_OR:    alu_res = op_a | op_b;
            ALU_AND:   alu_res = op_a & op_b;
            ALU_PASSB: alu_res = op_b;
            ALU_SEQ:   alu_res = {{XLEN-1{1'b0}}, op_a == op_b};
            ALU_SNE:   alu_res = {{XLEN-1{1'b0}}, op_a != op_b};
            ALU_MUL, ALU_DIVU, ALU_REMU: alu_res = '0;
        endcase
    end

    always_comb begin
        ex_res    = alu_res;
        ex_taken  = 1'b0;
        ex_target = '0;
        if (op_data[OP_JUMP]) begin
            ex_res    = PC + XLEN'(4);
            ex_taken  = 1'b1;
            ex_target = op_data[OP_USE_PC] ? PC + imm
                      : (r1 + imm) & {{XLEN-1{1'b1}}, 1'b0};
        end else if (op_data[OP_BRANCH]) begin
            ex_taken  = alu_res[0];
            ex_target = PC + imm;
        end
    end

    mul_div_iter u_md (
        .clk       (clk),
        .rst       (rst),
        .start     (md_start),
        .step      (md_step),
        .op        (alu_op),
        .a         (op_a),
        .b         (op_b),
        .result    (md_result),
        .last_step (md_last)
    );

    always_comb begin
        state_d  = state_q;
        rd_lat_d = rd_lat_q;
        op_lat_d = op_lat_q;
        r2_lat_d = r2_lat_q;
        res_d    = res_q;
        r2o_d    = r2o_q;
        rdo_d    = rdo_q;
        opo_d    = opo_q;
        tk_d     = tk_q;
        tgt_d    = tgt_q;
        md_start = 1'b0;
        md_step  = 1'b0;
        if (en) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (md_op) begin
                        md_start = 1'b1;
                        rd_lat_d = rd;
                        op_lat_d = op_data;
                        r2_lat_d = r2;
                        state_d  = ST_BUSY;
                        res_d    = '0;
                        r2o_d    = '0;
                        rdo_d    = '0;
                        opo_d    = '0;
                        tk_d     = 1'b0;
                        tgt_d    = '0;
                    end else begin
                        res_d = ex_res;
                        r2o_d = r2;
                        rdo_d = rd;
                        opo_d = op_data;
                        tk_d  = ex_taken;
                        tgt_d = ex_target;
                    end
                end
                ST_BUSY: begin
                    md_step = 1'b1;
                    tk_d    = 1'b0;
                    tgt_d   = '0;
                    if (md_last) begin
                        state_d = ST_IDLE;
                        res_d   = md_result;
                        r2o_d   = r2_lat_q;
                        rdo_d   = rd_lat_q;
                        opo_d   = op_lat_q;
                    end else begin
                        res_d = '0;
                        r2o_d = '0;
                        rdo_d = '0;
                        opo_d = '0;
                    end
                end
            endcase
        end
    end

    // Drops on the final step so upstream advances with the result write
    assign stall = rst
                 && (((state_q == ST_IDLE) && en && md_op)
                 || ((state_q == ST_BUSY) && !md_last));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            rd_lat_q <= '0;
            op_lat_q <= '0;
            r2_lat_q <= '0;
            res_q    <= '0;
            r2o_q    <= '0;
            rdo_q    <= '0;
            opo_q    <= '0;
            tk_q     <= 1'b0;
            tgt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rd_lat_q <= rd_lat_d;
            op_lat_q <= op_lat_d;
            r2_lat_q <= r2_lat_d;
            res_q    <= res_d;
            r2o_q    <= r2o_d;
            rdo_q    <= rdo_d;
            opo_q    <= opo_d;
            tk_q     <= tk_d;
            tgt_q    <= tgt_d;
        end
    end

    assign alu_result_out    = res_q;
    assign r2_out            = r2o_q;
    assign rd_out            = rdo_q;
    assign op_data_out       = opo_q;
    assign branch_taken_out  = tk_q;
    assign branch_target_out = tgt_q;

endmodule
